mac_lookup_arb: RTL

MAC_LOOKUP_ARB -- requirements
Module: mac_lookup_arb

---
 rtl/mac_lookup_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mac_lookup_arb.sv
// Round-robin MAC lookup arbiter: one outstanding lookup per requester,
// result routing by tag, and lowest-index forced timeout (flood) responses.
module mac_lookup_arb #(
    parameter int REQ_NUM = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [48*REQ_NUM-1:0] i_req_mac,
    input  logic [REQ_NUM-1:0]    i_req_valid,
    output logic [REQ_NUM-1:0]    o_req_ready,
    output logic [47:0]           o_check_mac,
    output logic [3:0]            o_check_id,
    output logic                  o_check_valid,
    input  logic [3:0]            i_outport,
    input  logic                  i_result_valid,
    input  logic [3:0]            i_check_id,
    output logic [3:0]            o_rsp_outport,
    output logic [REQ_NUM-1:0]    o_rsp_valid,
    output logic                  o_rsp_timeout,
    output logic                  o_err_unexpected
);

    logic [REQ_NUM-1:0] busy;
    logic [15:0]        timer [REQ_NUM];
    logic [3:0]         last_grant;

    logic               gnt_any;
    logic [3:0]         gnt_id;
    logic [47:0]        gnt_mac;
    logic [REQ_NUM-1:0] gnt_vec;
    int                 idx;

    logic [REQ_NUM-1:0] res_vec;
    logic               res_hit;
    logic               res_err;
    logic [REQ_NUM-1:0] to_vec;
    logic               to_any;
    logic [REQ_NUM-1:0] done_vec;

    // Search starts one past the last winner and wraps around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        gnt_mac = '0;
        gnt_vec = '0;
        idx     = 0;
        for (int i = 1; i <= REQ_NUM; i++) begin
            idx = (int'(last_grant) + i) % REQ_NUM;
            if (!gnt_any && i_req_valid[idx] && !busy[idx]) begin
                gnt_any      = 1'b1;
                gnt_id       = 4'(idx);
                gnt_mac      = i_req_mac[48*idx +: 48];
                gnt_vec[idx] = 1'b1;
            end
        end
    end

    assign o_req_ready = i_rst ? gnt_vec : '0;

    always_comb begin
        res_vec = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (i_check_id == 4'(k) && busy[k]) res_vec[k] = 1'b1;
        end
        res_hit = i_result_valid && (|res_vec);
        res_err = i_result_valid && !(|res_vec);
    end

    // A real result wins; a deferred timeout simply stays eligible.
    always_comb begin
        to_vec = '0;
        to_any = 1'b0;
        if (!res_hit) begin
            for (int k = 0; k < REQ_NUM; k++) begin
                if (!to_any && busy[k] && timer[k] >= 16'(TIMEOUT)) begin
                    to_any    = 1'b1;
                    to_vec[k] = 1'b1;
                end
            end
        end
        done_vec = (res_hit ? res_vec : '0) | to_vec;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            busy             <= '0;
            last_grant       <= 4'(REQ_NUM - 1);
            o_check_mac      <= '0;
            o_check_id       <= '0;
            o_check_valid    <= 1'b0;
            o_rsp_outport    <= '0;
            o_rsp_valid      <= '0;
            o_rsp_timeout    <= 1'b0;
            o_err_unexpected <= 1'b0;
            for (int k = 0; k < REQ_NUM; k++) timer[k] <= '0;
        end else begin
            o_check_valid    <= gnt_any;
            o_rsp_valid      <= done_vec;
            o_rsp_timeout    <= to_any;
            o_err_unexpected <= res_err;
            if (gnt_any) begin
                o_check_mac <= gnt_mac;
                o_check_id  <= gnt_id;
                last_grant  <= gnt_id;
            end
            if (res_hit) begin
                o_rsp_outport <= i_outport;
            end else if (to_any) begin
                o_rsp_outport <= 4'hF;
            end
            for (int k = 0; k < REQ_NUM; k++) begin
                if (gnt_vec[k]) begin
                    busy[k]  <= 1'b1;
                    timer[k] <= '0;
                end else if (done_vec[k]) begin
                    busy[k]  <= 1'b0;
                    timer[k] <= '0;
                end else if (busy[k] && timer[k] != 16'hFFFF) begin
                    timer[k] <= timer[k] + 16'd1;
                end
            end
        end
    end

endmodule
